// File: rtl/cic_decim_comb.sv
// cic_decim_comb: decimate-by-R plus D pipelined comb (differentiator) stages,
// differential delay of one decimated sample. Consumes the full-rate, wrapping
// two's-complement output of a matching D-stage integrator and emits one
// strobe-qualified, optionally scaled sample per decimated period.
// All comb arithmetic wraps modulo 2^INPUT_WIDTH, matching the integrator.
module cic_decim_comb #(
    parameter int D            = 3,
    parameter int R            = 8,
    parameter int INPUT_WIDTH  = 20,
    parameter int OUTPUT_WIDTH = 20,
    parameter int SHIFT        = 0,
    localparam int PHASE_WIDTH = (R > 1) ? $clog2(R) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  Xin,
    input  logic                           Xvalid,
    output logic signed [OUTPUT_WIDTH-1:0] Dout,
    output logic                           Dvalid,
    output logic [PHASE_WIDTH-1:0]         Phase
);

    // Parameter sanity: the output window must lie inside the comb word.
    if (SHIFT + OUTPUT_WIDTH > INPUT_WIDTH) begin : gBadOutputWindow
        $error("cic_decim_comb: SHIFT + OUTPUT_WIDTH must not exceed INPUT_WIDTH");
    end
    if (R < 1) begin : gBadRatio
        $error("cic_decim_comb: R must be at least 1");
    end
    if (D < 1) begin : gBadStages
        $error("cic_decim_comb: D must be at least 1");
    end

    logic [PHASE_WIDTH-1:0] phase_q;
    logic [PHASE_WIDTH-1:0] phase_d;
    logic                   lastPhase;
    logic [INPUT_WIDTH-1:0] dec_q;
    logic                   v0_q;

    // Stage k reads stageX[k-1]/stageV[k-1]; index 0 is the decimation register.
    logic [D:0][INPUT_WIDTH-1:0] stageX;
    logic [D:0]                  stageV;

    // Phase counter next state: advances only on valid input, wrapping at R-1.
    always_comb begin
        lastPhase = (phase_q == PHASE_WIDTH'(R - 1));
        phase_d   = phase_q;
        if (Xvalid) begin
            phase_d = lastPhase ? '0 : phase_q + 1'b1;
        end
    end

    // Decimation: keep the last valid sample of each period of R valid inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            dec_q   <= '0;
            v0_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            v0_q    <= Xvalid && lastPhase;
            if (Xvalid && lastPhase) begin
                dec_q <= Xin;
            end
        end
    end

    assign stageX[0] = dec_q;
    assign stageV[0] = v0_q;

    for (genvar k = 1; k <= D; k++) begin : gComb
        logic [INPUT_WIDTH-1:0] dly_q;
        logic [INPUT_WIDTH-1:0] diff_q;
        logic                   v_q;

        // Comb stage: difference against the previous decimated sample, only
        // updated when the upstream stage presents a new sample.
        always_ff @(posedge clk) begin
            if (rst) begin
                dly_q  <= '0;
                diff_q <= '0;
                v_q    <= 1'b0;
            end else begin
                v_q <= stageV[k-1];
                if (stageV[k-1]) begin
                    diff_q <= stageX[k-1] - dly_q;
                    dly_q  <= stageX[k-1];
                end
            end
        end

        assign stageX[k] = diff_q;
        assign stageV[k] = v_q;
    end

    // Scaling is a plain bit-window of the final comb register, so Dout holds
    // its value between strobes for free.
    assign Dout   = stageX[D][SHIFT+OUTPUT_WIDTH-1:SHIFT];
    assign Dvalid = stageV[D];
    assign Phase  = phase_q;

endmodule

// File: tb/tb_cic_decim_comb.sv
// tb_cic_decim_comb: self-checking bench for cic_decim_comb.
// Main instance D=3,R=8 (plus a SHIFT=4 twin on the same inputs) is checked
// every cycle against a sample-level model: decimate, then take the D-th
// binomial difference of the decimated sequence, delivered D edges later.
// A D=1,R=1 instance is checked from a vector table for wrap-around.
module tb_cic_decim_comb;

    localparam int D  = 3;
    localparam int R  = 8;
    localparam int IW = 20;

    typedef struct {
        int          due;
        logic [19:0] val;
    } pend_t;

    typedef struct {
        logic [19:0] xin;
        logic        xvalid;
        logic        expValid;
        logic [19:0] expDout;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [19:0] xin;
    logic        xvalid;
    logic [19:0] dout;
    logic        dvalid;
    logic [2:0]  phase;
    logic [15:0] doutS;
    logic        dvalidS;
    logic [2:0]  phaseS;
    logic [19:0] xinR1;
    logic        xvalidR1;
    logic [19:0] doutR1;
    logic        dvalidR1;
    logic [0:0]  phaseR1;

    int checkCount;
    int passCount;
    int cyc;

    int          phaseModel;
    logic [19:0] decHist[$];
    pend_t       pending[$];
    logic [19:0] lastOut;
    logic [19:0] strobeLog[$];
    logic [15:0] strobeLogS[$];
    int          strobeCyc[$];
    vec_t        vecs[8];

    cic_decim_comb #(.D(D), .R(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(20), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .Xin(xin), .Xvalid(xvalid),
        .Dout(dout), .Dvalid(dvalid), .Phase(phase)
    );

    cic_decim_comb #(.D(D), .R(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(16), .SHIFT(4)) dutShift (
        .clk(clk), .rst(rst), .Xin(xin), .Xvalid(xvalid),
        .Dout(doutS), .Dvalid(dvalidS), .Phase(phaseS)
    );

    cic_decim_comb #(.D(1), .R(1), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(20), .SHIFT(0)) dutR1 (
        .clk(clk), .rst(rst), .Xin(xinR1), .Xvalid(xvalidR1),
        .Dout(doutR1), .Dvalid(dvalidR1), .Phase(phaseR1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = r * (n - i) / (i + 1);
        end
        return r;
    endfunction

    // D-th difference of the decimated sequence, history before reset is zero.
    function automatic logic [19:0] combModel();
        logic [31:0] acc;
        logic [31:0] term;
        int          idx;
        acc = '0;
        for (int j = 0; j <= D; j++) begin
            idx = decHist.size() - 1 - j;
            if (idx >= 0) begin
                term = 32'(binom(D, j)) * {12'b0, decHist[idx]};
                acc  = (j % 2 == 0) ? acc + term : acc - term;
            end
        end
        return acc[19:0];
    endfunction

    task automatic checkOutput();
        logic              expValid;
        logic signed [19:0] sv;
        logic [19:0]       sh;
        expValid = (pending.size() > 0) && (pending[0].due == cyc);
        if (expValid) begin
            lastOut = pending[0].val;
            void'(pending.pop_front());
        end
        sv = lastOut;
        sh = sv >>> 4;
        check("Dvalid", 32'(dvalid), 32'(expValid));
        check("Dout", 32'(dout), 32'(lastOut));
        check("Phase", 32'(phase), 32'(phaseModel));
        check("DvalidShift", 32'(dvalidS), 32'(expValid));
        check("DoutShift", 32'(doutS), 32'(sh[15:0]));
        if (dvalid) begin
            strobeLog.push_back(dout);
            strobeLogS.push_back(doutS);
            strobeCyc.push_back(cyc);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] x, input logic v, input logic r);
        xin    = x;
        xvalid = v;
        rst    = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            pending.delete();
            decHist.delete();
            phaseModel = 0;
            lastOut    = '0;
        end else if (v) begin
            if (phaseModel == R - 1) begin
                decHist.push_back(x);
                pending.push_back('{due: cyc + D, val: combModel()});
                phaseModel = 0;
            end else begin
                phaseModel++;
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic clearLog();
        strobeLog.delete();
        strobeLogS.delete();
        strobeCyc.delete();
    endtask

    task automatic checkConstFiveLog(input string tag, input int spacing);
        logic [19:0] expV[5];
        logic [15:0] expS[5];
        expV = '{20'h00005, 20'hFFFF6, 20'h00005, 20'h00000, 20'h00000};
        expS = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        check({tag, " strobeCount"}, 32'(strobeLog.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check({tag, " value"}, 32'(strobeLog[i]), 32'(expV[i]));
            check({tag, " shiftedValue"}, 32'(strobeLogS[i]), 32'(expS[i]));
        end
        for (int i = 1; i < 4; i++) begin
            check({tag, " spacing"}, 32'(strobeCyc[i] - strobeCyc[i-1]), 32'(spacing));
        end
    endtask

    initial begin
        int          edgeE;
        logic [19:0] s1;
        logic [19:0] s2;
        logic [19:0] s3;

        vecs[0] = '{20'h7FFFF, 1'b1, 1'b0, 20'h00000};
        vecs[1] = '{20'h80001, 1'b1, 1'b1, 20'h7FFFF};
        vecs[2] = '{20'h00000, 1'b0, 1'b1, 20'h00002};
        vecs[3] = '{20'h00000, 1'b0, 1'b0, 20'h00002};
        vecs[4] = '{20'h00003, 1'b1, 1'b0, 20'h00002};
        vecs[5] = '{20'h00003, 1'b1, 1'b1, 20'h80002};
        vecs[6] = '{20'h00000, 1'b0, 1'b1, 20'h00000};
        vecs[7] = '{20'h00000, 1'b0, 1'b0, 20'h00000};

        checkCount = 0;
        passCount  = 0;
        cyc        = 0;
        phaseModel = 0;
        lastOut    = '0;
        xinR1      = '0;
        xvalidR1   = 1'b0;

        applyStimulus(20'h0, 1'b0, 1'b1);
        applyStimulus(20'h0, 1'b0, 1'b1);

        // Constant 5, free-running: 5,-10,5,0,0 every 8 clocks.
        clearLog();
        for (int i = 0; i < 48; i++) applyStimulus(20'd5, 1'b1, 1'b0);
        checkConstFiveLog("constFive", 8);

        // Same with Xvalid toggling: same values, every 16 clocks.
        applyStimulus(20'h0, 1'b0, 1'b1);
        clearLog();
        for (int i = 0; i < 96; i++) applyStimulus(20'd5, (i % 2 == 0), 1'b0);
        checkConstFiveLog("toggleValid", 16);

        // Reset after a partial period must look like a cold start.
        applyStimulus(20'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(20'd5, 1'b1, 1'b0);
        applyStimulus(20'd5, 1'b1, 1'b1);
        check("midReset Dout", 32'(dout), 32'd0);
        check("midReset Dvalid", 32'(dvalid), 32'd0);
        check("midReset Phase", 32'(phase), 32'd0);
        clearLog();
        for (int i = 0; i < 48; i++) applyStimulus(20'd5, 1'b1, 1'b0);
        checkConstFiveLog("afterReset", 8);

        // Latency: Dvalid only in the cycle after edge E+D.
        applyStimulus(20'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(20'd9, 1'b1, 1'b0);
        applyStimulus(20'd9, 1'b1, 1'b0);
        edgeE = cyc;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(20'd0, 1'b0, 1'b0);
            check("latency Dvalid", 32'(dvalid), 32'(cyc == edgeE + D));
        end

        // Chained after an ideal 3-stage integrator with DC input 1.
        applyStimulus(20'h0, 1'b0, 1'b1);
        clearLog();
        s1 = '0;
        s2 = '0;
        s3 = '0;
        for (int i = 0; i < 80; i++) begin
            s1 = s1 + 20'd1;
            s2 = s2 + s1;
            s3 = s3 + s2;
            applyStimulus(s3, 1'b1, 1'b0);
        end
        check("chain strobeCount", 32'(strobeLog.size() >= 8), 32'd1);
        for (int i = 3; i < 8; i++) begin
            check("chain settled", 32'(strobeLog[i]), 32'd512);
        end

        // Randomized traffic with occasional resets.
        applyStimulus(20'h0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            applyStimulus(20'($urandom), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 99) == 0));
        end

        // D=1,R=1 vector table exercising modulo-2^20 wrap.
        applyStimulus(20'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            xinR1    = vecs[i].xin;
            xvalidR1 = vecs[i].xvalid;
            applyStimulus(20'h0, 1'b0, 1'b0);
            check("r1 Dvalid", 32'(dvalidR1), 32'(vecs[i].expValid));
            check("r1 Dout", 32'(doutR1), 32'(vecs[i].expDout));
            check("r1 Phase", 32'(phaseR1), 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
